// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: active-low column strobes, debounced row sense, valid/read key register.
// Optional KEY_REPEAT_EN adds auto-repeat while a key is held.
module keypad_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_TICKS = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  input  logic       key_rd,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic       overrun
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CNT - 1);

  if (SCAN_DIV < 4 || DEBOUNCE_CNT < 2 || REPEAT_TICKS < 1) begin : g_param_chk
    $error("keypad_scanner: parameter out of range");
  end

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_t;

  state_t state, state_d;

  logic [3:0]    r1, rs;
  logic [DW-1:0] div;
  logic          tick;
  logic [3:0]    col_d, col_rot;
  logic [3:0]    cand, cand_d;
  logic [CW-1:0] stab, stab_d;
  logic [CW-1:0] rel, rel_d;
  logic          accept;
  logic          one_low;
  logic [1:0]    row_idx, col_idx;
  logic          rd;

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_TICKS - 1);
  logic [RW-1:0] rep, rep_d;
`endif

  assign tick    = (div == DIV_MAX);
  assign col_rot = {col[2:0], col[3]};
  assign rd      = key_rd & key_valid;
  assign key_down = (state == HELD);

  // Two or more rows low (ghosting) decodes as no key.
  always_comb begin
    one_low = 1'b1;
    row_idx = 2'd0;
    case (rs)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  always_comb begin
    col_idx = 2'd0;
    case (col)
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state;
    col_d   = col;
    cand_d  = cand;
    stab_d  = stab;
    rel_d   = rel;
    accept  = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_d   = rep;
`endif
    if (tick) begin
      unique case (state)
        SCAN: begin
          if (one_low) begin
            cand_d  = {row_idx, col_idx};
            stab_d  = CW'(1);
            state_d = DEBOUNCE;
          end else begin
            col_d = col_rot;
          end
        end
        DEBOUNCE: begin
          if (one_low && row_idx == cand[3:2]) begin
            if (stab == DB_LAST) begin
              accept  = 1'b1;
              stab_d  = '0;
              rel_d   = '0;
              state_d = HELD;
`ifdef KEY_REPEAT_EN
              rep_d   = '0;
`endif
            end else begin
              stab_d = stab + CW'(1);
            end
          end else begin
            stab_d  = '0;
            col_d   = col_rot;
            state_d = SCAN;
          end
        end
        HELD: begin
          if (rs == 4'hF) begin
            if (rel == DB_LAST) begin
              rel_d   = '0;
              col_d   = col_rot;
              state_d = SCAN;
`ifdef KEY_REPEAT_EN
              rep_d   = '0;
`endif
            end else begin
              rel_d = rel + CW'(1);
            end
          end else begin
            rel_d = '0;
`ifdef KEY_REPEAT_EN
            if (rep == RP_LAST) begin
              accept = 1'b1;
              rep_d  = '0;
            end else begin
              rep_d = rep + RW'(1);
            end
`endif
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r1        <= 4'hF;
      rs        <= 4'hF;
      div       <= '0;
      state     <= SCAN;
      col       <= 4'b1110;
      cand      <= '0;
      stab      <= '0;
      rel       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep       <= '0;
`endif
    end else begin
      r1    <= row;
      rs    <= r1;
      div   <= tick ? '0 : div + DW'(1);
      state <= state_d;
      col   <= col_d;
      cand  <= cand_d;
      stab  <= stab_d;
      rel   <= rel_d;
`ifdef KEY_REPEAT_EN
      rep   <= rep_d;
`endif
      // A same-cycle read acknowledges the old key, so no overrun.
      if (accept) begin
        key_code  <= cand;
        key_valid <= 1'b1;
        overrun   <= key_rd ? 1'b0 : (overrun | key_valid);
      end else if (rd) begin
        key_valid <= 1'b0;
        overrun   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a simple 4x4 key matrix model.
// Define KEY_REPEAT_EN to also exercise auto-repeat.
module tb_keypad_scanner;

  logic       clk;
  logic       reset;
  logic [3:0] row;
  logic       key_rd;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  logic       overrun;

  logic       pressed;
  logic [3:0] key;
  logic       manual;
  logic [3:0] row_man;

  int n_chk;
  int n_pass;

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_CNT(3),
    .REPEAT_TICKS(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .row(row),
    .key_rd(key_rd),
    .col(col),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_down(key_down),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A key pulls its row low only while its column is strobed.
  always_comb begin
    row = 4'hF;
    if (manual)
      row = row_man;
    else if (pressed && col[key[1:0]] == 1'b0)
      row[key[3:2]] = 1'b0;
  end

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_valid(input logic v, input string tag);
    int n = 0;
    while (key_valid !== v && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (key_valid !== v) check(tag, 8'(key_valid), 8'(v));
  endtask

  task automatic wait_down(input logic v, input string tag);
    int n = 0;
    while (key_down !== v && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (key_down !== v) check(tag, 8'(key_down), 8'(v));
  endtask

  task automatic wait_col(input logic [3:0] c, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (col !== c && n < 200);
    if (col !== c) check(tag, 8'(col), 8'(c));
  endtask

  task automatic pulse_rd;
    key_rd = 1'b1;
    @(negedge clk);
    key_rd = 1'b0;
  endtask

  task automatic press(input logic [3:0] k);
    key     = k;
    pressed = 1'b1;
  endtask

  initial begin
    int n;
    logic [3:0] c0;
    n_chk   = 0;
    n_pass  = 0;
    key_rd  = 1'b0;
    pressed = 1'b0;
    key     = 4'd0;
    manual  = 1'b0;
    row_man = 4'hF;
    reset   = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("rst_col", 8'(col), 8'h0E);
    check("rst_valid", 8'(key_valid), 8'h0);
    check("rst_down", 8'(key_down), 8'h0);
    check("rst_ovr", 8'(overrun), 8'h0);
    check("rst_code", 8'(key_code), 8'h0);

    repeat (3) @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (col == 4'b1110 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("scan_first_slot", 8'(n), 8'd4);
    check("scan_c1", 8'(col), 8'h0D);
    repeat (4) @(negedge clk);
    check("scan_c2", 8'(col), 8'h0B);
    repeat (4) @(negedge clk);
    check("scan_c3", 8'(col), 8'h07);
    repeat (4) @(negedge clk);
    check("scan_c0", 8'(col), 8'h0E);
    check("scan_idle", 8'({key_valid, key_down, overrun}), 8'h0);

    // key r2,c1 -> code 9
    press(4'd9);
    wait_valid(1'b1, "k9_tmo");
    check("k9_code", 8'(key_code), 8'd9);
    check("k9_col", 8'(col), 8'h0D);
    check("k9_down", 8'(key_down), 8'h1);
    check("k9_ovr", 8'(overrun), 8'h0);
    pulse_rd();
    check("k9_rd", 8'(key_valid), 8'h0);
    pressed = 1'b0;
    wait_down(1'b0, "k9_rel_tmo");
    check("k9_rel_col", 8'(col), 8'h0B);

    // one-tick bounce on row0 at col 1011
    manual  = 1'b1;
    row_man = 4'hF;
    wait_col(4'b1011, "bnc_col_tmo");
    row_man = 4'b1110;
    repeat (4) @(negedge clk);
    check("bnc_frozen", 8'(col), 8'h0B);
    row_man = 4'hF;
    repeat (4) @(negedge clk);
    check("bnc_resume", 8'(col), 8'h07);
    check("bnc_valid", 8'(key_valid), 8'h0);
    manual = 1'b0;
    press(4'd2);
    wait_valid(1'b1, "k2_tmo");
    check("k2_code", 8'(key_code), 8'd2);
    pulse_rd();
    pressed = 1'b0;
    wait_down(1'b0, "k2_rel_tmo");

    // two keys without read -> overrun
    press(4'd5);
    wait_down(1'b1, "k5_tmo");
    check("k5_code", 8'(key_code), 8'd5);
    pressed = 1'b0;
    wait_down(1'b0, "k5_rel_tmo");
    press(4'd15);
    wait_down(1'b1, "k15_tmo");
    check("k15_code", 8'(key_code), 8'd15);
    check("k15_valid", 8'(key_valid), 8'h1);
    check("k15_ovr", 8'(overrun), 8'h1);
    pulse_rd();
    check("ovr_rd", 8'({key_valid, overrun}), 8'h0);
    pressed = 1'b0;
    wait_down(1'b0, "k15_rel_tmo");

    // ghosting: two rows low is no key
    manual  = 1'b1;
    row_man = 4'b0011;
    @(negedge clk);
    c0 = col;
    repeat (4) @(negedge clk);
    check("ghost_rotate", 8'(col != c0), 8'h1);
    repeat (20) @(negedge clk);
    check("ghost_none", 8'({key_valid, key_down, overrun}), 8'h0);
    manual  = 1'b0;
    row_man = 4'hF;

    // read coincident with accept: accept wins, no overrun
    press(4'd6);
    wait_down(1'b1, "k6_tmo");
    check("k6_code", 8'(key_code), 8'd6);
    pressed = 1'b0;
    wait_down(1'b0, "k6_rel_tmo");
    press(4'd10);
    wait_col(4'b1011, "k10_col_tmo");
    repeat (11) @(negedge clk);
    check("k10_pre", 8'({key_valid, key_down}), 8'h2);
    pulse_rd();
    check("k10_valid", 8'(key_valid), 8'h1);
    check("k10_ovr", 8'(overrun), 8'h0);
    check("k10_code", 8'(key_code), 8'd10);
    check("k10_down", 8'(key_down), 8'h1);
    pressed = 1'b0;
    wait_down(1'b0, "k10_rel_tmo");

    // async reset mid-debounce
    press(4'd0);
    wait_col(4'b1110, "k0_col_tmo");
    repeat (6) @(negedge clk);
    check("mid_db_valid", 8'(key_valid), 8'h1);
    #1 reset = 1'b0;
    #1;
    check("arst_col", 8'(col), 8'h0E);
    check("arst_code", 8'(key_code), 8'h0);
    check("arst_flags", 8'({key_valid, key_down, overrun}), 8'h0);
    @(negedge clk);
    reset = 1'b1;

`ifdef KEY_REPEAT_EN
    wait_valid(1'b1, "rep_first_tmo");
    check("rep_code0", 8'(key_code), 8'd0);
    n = 0;
    key_rd = 1'b1;
    @(negedge clk);
    n++;
    key_rd = 1'b0;
    while (!key_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rep_period", 8'(n), 8'd20);
    check("rep_code", 8'(key_code), 8'd0);
    check("rep_ovr0", 8'(overrun), 8'h0);
    repeat (20) @(negedge clk);
    check("rep_ovr1", 8'(overrun), 8'h1);
`endif
    pressed = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Input-side counterpart of the alarm panel's multiplexed 7-segment display driver. Where the display walks one-hot anode strobes to push digits out, this block walks active-low column strobes across a 4x4 arm/disarm keypad and reads the row lines back. It debounces presses and delivers one 4-bit key code per press to the alarm controller through a valid/read holding register.

Parameters:
SCAN_DIV, 50000, clk cycles per column slot (tick period); min 4
DEBOUNCE_CNT, 4, consecutive stable ticks needed to accept a press or a release; min 2
REPEAT_TICKS, 200, ticks between auto-repeat codes (used only with KEY_REPEAT_EN)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
row  input  4  keypad rows, active-low, externally pulled up, asynchronous
key_rd  input  1  consumer read strobe, 1 cycle; clears key_valid
col  output  4  column strobes, active-low one-hot
key_code  output  4  accepted key = row_idx*4 + col_idx
key_valid  output  1  key_code holds an unread key
key_down  output  1  high while the accepted key is held (HELD state)
overrun  output  1  sticky: a key was lost because key_valid was still set

Behaviour:
- Reset (reset=0, async): col=4'b1110, key_code=0, key_valid=0, key_down=0, overrun=0, state=SCAN, all counters 0.
- row passes through a 2-flop synchronizer. All decisions use the synchronized value rs.
- Tick: a divider counts 0..SCAN_DIV-1. At terminal count, rs is sampled for the currently driven column. col changes only at a tick, so every sample sees a column that has been driven for a full slot.
- Row decode: rs with exactly one bit low gives a valid row_idx. All-high means no key. Two or more low bits count as no key (ghosting ignored).
- SCAN state: on each tick, if there is no key, rotate col (1110 -> 1101 -> 1011 -> 0111 -> 1110). If there is a valid key, freeze col, latch the candidate code, set stable count to 1, and go to DEBOUNCE.
- DEBOUNCE state: col stays frozen. On each tick:
  - same single row low: count+1; when count reaches DEBOUNCE_CNT, accept the key and go to HELD.
  - anything else: count=0, go to SCAN. Rotation resumes with the next column.
- Accept (one clk edge):
  - key_code <= candidate, key_valid <= 1.
  - If key_valid was already 1 and key_rd is not asserted in that cycle, overrun <= 1.
- HELD state: col stays frozen, key_down=1. Release is counted on ticks with rs all-high. Any non-release tick resets the release count. When the release count reaches DEBOUNCE_CNT: key_down=0, rotate col, go to SCAN.
- key_rd:
  - clears key_valid and overrun on the next edge.
  - If key_rd and an accept occur in the same cycle, the accept wins: key_valid stays 1, key_code is updated, no overrun.
  - key_rd while key_valid=0 has no effect.
- Latency: from the row going low to key_valid=1 is 2 clk (sync) plus up to DEBOUNCE_CNT full ticks, plus scan position.
- A press in a different column during HELD is ignored until release.
- Reset asserted mid-debounce or mid-hold aborts immediately to the reset values. No partial key is delivered.

Optional Feature:
KEY_REPEAT_EN
- Defined: in HELD, a repeat counter increments each tick the key stays pressed. At REPEAT_TICKS it re-accepts the same key_code (same overrun rules) and restarts from 0. It is cleared on leaving HELD.
- Undefined: exactly one accept per press. REPEAT_TICKS is unused and there is no repeat counter logic.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_CNT=3.
- Reset release, no keys -> col cycles 1110, 1101, 1011, 0111 every 4 clk. key_valid, key_down and overrun stay 0.
- Hold row[2] low while col=1101 (key r2,c1) -> col freezes at 1101. key_code=9 and key_valid=1 on the 3rd stable tick, key_down=1. Pulse key_rd -> key_valid=0 next edge.
- Bounce: row[0] low for 1 tick then high (col 1011) -> no key_valid, scan resumes at 0111. A later stable press -> key_code=2.
- Two keys without key_rd (codes 5 then 15) -> key_code=15, key_valid=1, overrun=1. key_rd clears both.
- row=4'b0011 (two rows low) -> treated as no key, scan continues, no output change. key_rd coincident with accept -> key_valid remains 1, overrun 0.
- Drive reset low mid-DEBOUNCE -> col=1110 and all outputs 0 asynchronously. With KEY_REPEAT_EN and REPEAT_TICKS=5, holding key 0 gives a new accept every 5 ticks after the first.
